// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Purpose:
//   Shares one single-port synchronous video RAM between two requesters in
//   the pixel_clk domain:
//     - the display pixel fetcher, which has fixed highest priority and is
//       never stalled (at most one read per cycle);
//     - the game-logic/CPU port, a level req / pulse ack handshake that is
//       only served in cycles the display leaves free (and, when BLANK_ONLY
//       is set, only while the display is blanking).
//   The RAM returns read data one cycle after the access, so a one-bit tag
//   remembers who issued the read in flight and steers mem_rdata back to
//   the right requester.
//
// Parameters:
//   ADDR_W       RAM word address width
//   DATA_W       RAM word width
//   BLANK_ONLY   1 = CPU served only while disp_ena==0, 0 = any free cycle
//   STALL_LIMIT  CPU wait cycles after which cpu_starved is raised
//
// Ports:
//   pixel_clk    in   clock, all logic on the rising edge
//   reset        in   synchronous active-high reset
//   disp_ena     in   display-active flag from the VGA timing generator
//   disp_req     in   display read strobe
//   disp_addr    in   display read address
//   disp_rvalid  out  display read data valid, 2 cycles after disp_req
//   disp_rdata   out  display read data
//   cpu_req      in   CPU request level, held until cpu_ack
//   cpu_we       in   CPU write (1) / read (0)
//   cpu_addr     in   CPU address
//   cpu_wdata    in   CPU write data
//   cpu_ack      out  one-cycle completion pulse
//   cpu_rdata    out  CPU read data, valid with cpu_ack on reads
//   cpu_starved  out  sticky flag: a CPU wait reached STALL_LIMIT
//   mem_en       out  RAM access enable
//   mem_we       out  RAM write enable
//   mem_addr     out  RAM address
//   mem_wdata    out  RAM write data
//   mem_rdata    in   RAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int BLANK_ONLY  = 0,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              disp_ena,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starved,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W     = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Read tag values: who owns the read currently returning from the RAM.
  localparam logic TAG_DISP = 1'b0;
  localparam logic TAG_CPU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_WAIT = 2'd2,
    RD_ACK  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_tag_q, rd_tag_d;
  logic              disp_rvalid_q, disp_rvalid_d;
  logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              cpu_starved_q, cpu_starved_d;

  logic              blank_ok;
  logic              disp_grant;
  logic              cpu_grant;

  // Grant decision for the current cycle. The display wins whenever it asks;
  // the CPU only gets a free cycle while the FSM is idle, and optionally only
  // during blanking. Reset suppresses both grants so the RAM sees no access
  // at all while reset is held.
  always_comb begin
    blank_ok   = (BLANK_ONLY == 0) || !disp_ena;
    disp_grant = disp_req && !reset;
    cpu_grant  = (state_q == IDLE) && cpu_req && !disp_req && blank_ok && !reset;
  end

  // RAM port drive, purely combinational from this cycle's grant. Address and
  // write data are forced to zero when nobody owns the port so the bus is
  // quiet and easy to follow on a waveform.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_grant) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (cpu_grant) begin
      mem_en   = 1'b1;
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      if (cpu_we) begin
        mem_wdata = cpu_wdata;
      end
    end
  end

  // CPU transaction FSM. A write completes the cycle after its grant; a read
  // waits one cycle for the RAM data, captures it, and acks the cycle after.
  // No new CPU grant is possible outside IDLE, which is what limits write
  // throughput to one per two cycles and reads to one per three.
  always_comb begin
    state_d   = state_q;
    cpu_ack_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_grant) begin
          if (cpu_we) begin
            state_d   = WR_ACK;
            cpu_ack_d = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      WR_ACK: begin
        state_d = IDLE;
      end
      RD_WAIT: begin
        state_d   = RD_ACK;
        cpu_ack_d = 1'b1;
      end
      RD_ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read return routing. The tag and valid bit describe the read issued last
  // cycle, which is exactly the read whose data is on mem_rdata now, so a
  // display read interleaved with a CPU read can never be mis-delivered.
  // Both read data registers hold their value between deliveries.
  always_comb begin
    rd_vld_d      = disp_grant || (cpu_grant && !cpu_we);
    rd_tag_d      = disp_grant ? TAG_DISP : TAG_CPU;
    if (!rd_vld_d) begin
      rd_tag_d = TAG_DISP;
    end
    disp_rvalid_d = rd_vld_q && (rd_tag_q == TAG_DISP);
    disp_rdata_d  = disp_rdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    if (disp_rvalid_d) begin
      disp_rdata_d = mem_rdata;
    end
    if (rd_vld_q && (rd_tag_q == TAG_CPU)) begin
      cpu_rdata_d = mem_rdata;
    end
  end

  // Starvation monitor. Every idle cycle in which the CPU is asking but is
  // not granted counts as a stall; the count saturates at STALL_LIMIT and is
  // cleared by a grant. Reaching the limit sets a flag that only reset clears.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_grant) begin
      stall_cnt_d = '0;
    end else if ((state_q == IDLE) && cpu_req && (stall_cnt_q < STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    cpu_starved_d = cpu_starved_q || (stall_cnt_d == STALL_MAX);
  end

  // State register. A synchronous reset drops any pending ack or display
  // data-valid; the requester has to re-issue its access afterwards.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rd_vld_q      <= 1'b0;
      rd_tag_q      <= TAG_DISP;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      stall_cnt_q   <= '0;
      cpu_starved_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_vld_q      <= rd_vld_d;
      rd_tag_q      <= rd_tag_d;
      disp_rvalid_q <= disp_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      stall_cnt_q   <= stall_cnt_d;
      cpu_starved_q <= cpu_starved_d;
    end
  end

  assign disp_rvalid = disp_rvalid_q;
  assign disp_rdata  = disp_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_starved = cpu_starved_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Two arbiters share one set of stimulus: dutA (BLANK_ONLY=0, STALL_LIMIT=4)
// and dutB (BLANK_ONLY=1, default STALL_LIMIT). Each has its own RAM model
// whose contents are a fixed function of the address (low byte + 0x40, with
// 0x0010 holding 0x3C); the last write is remembered for readback.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic        disp_ena;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;

  logic        a_disp_rvalid, a_cpu_ack, a_cpu_starved, a_mem_en, a_mem_we;
  logic [7:0]  a_disp_rdata, a_cpu_rdata, a_mem_wdata, a_mem_rdata;
  logic [15:0] a_mem_addr;
  logic        b_disp_rvalid, b_cpu_ack, b_cpu_starved, b_mem_en, b_mem_we;
  logic [7:0]  b_disp_rdata, b_cpu_rdata, b_mem_wdata, b_mem_rdata;
  logic [15:0] b_mem_addr;

  logic        a_wseen, b_wseen;
  logic [15:0] a_waddr, b_waddr;
  logic [7:0]  a_wdata, b_wdata;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic        rst;
    logic        dreq;
    logic [15:0] daddr;
    logic        creq;
    logic        cwe;
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic        eEn;
    logic        eWe;
    logic [15:0] eAddr;
    logic [7:0]  eWd;
    logic        eAck;
    logic        eDv;
    logic [7:0]  eDd;
    logic        eStarv;
    logic [7:0]  eCrd;
  } vec_t;

  vec_t vecs[$];

  always #5 pixel_clk = ~pixel_clk;

  vram_arbiter #(.ADDR_W(16), .DATA_W(8), .BLANK_ONLY(0), .STALL_LIMIT(4)) dutA (
    .pixel_clk(pixel_clk), .reset(reset), .disp_ena(disp_ena),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(a_disp_rvalid), .disp_rdata(a_disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata), .cpu_starved(a_cpu_starved),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  vram_arbiter #(.ADDR_W(16), .DATA_W(8), .BLANK_ONLY(1)) dutB (
    .pixel_clk(pixel_clk), .reset(reset), .disp_ena(disp_ena),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(b_disp_rvalid), .disp_rdata(b_disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata), .cpu_starved(b_cpu_starved),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Fixed RAM contents used by both RAM models.
  function automatic logic [7:0] ramInit(input logic [15:0] addr);
    if (addr == 16'h0010) return 8'h3C;
    return addr[7:0] + 8'h40;
  endfunction

  // Synchronous single-port RAM models with one-cycle read latency.
  always @(posedge pixel_clk) begin
    if (reset) begin
      a_wseen <= 1'b0;
    end else if (a_mem_en && a_mem_we) begin
      a_wseen <= 1'b1;
      a_waddr <= a_mem_addr;
      a_wdata <= a_mem_wdata;
    end
    if (a_mem_en && !a_mem_we) begin
      a_mem_rdata <= (a_wseen && a_waddr == a_mem_addr) ? a_wdata : ramInit(a_mem_addr);
    end
  end

  always @(posedge pixel_clk) begin
    if (reset) begin
      b_wseen <= 1'b0;
    end else if (b_mem_en && b_mem_we) begin
      b_wseen <= 1'b1;
      b_waddr <= b_mem_addr;
      b_wdata <= b_mem_wdata;
    end
    if (b_mem_en && !b_mem_we) begin
      b_mem_rdata <= (b_wseen && b_waddr == b_mem_addr) ? b_wdata : ramInit(b_mem_addr);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, return at the
  // falling edge where outputs are sampled.
  task automatic driveCycle(input logic rst, input logic dena, input logic dreq,
                            input logic [15:0] daddr, input logic creq, input logic cwe,
                            input logic [15:0] caddr, input logic [7:0] cwd);
    @(posedge pixel_clk);
    #1;
    reset     = rst;
    disp_ena  = dena;
    disp_req  = dreq;
    disp_addr = daddr;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwd;
    @(negedge pixel_clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    driveCycle(v.rst, 1'b0, v.dreq, v.daddr, v.creq, v.cwe, v.caddr, v.cwd);
  endtask

  task automatic addVec(input logic rst, input logic dreq, input logic [15:0] daddr,
                        input logic creq, input logic cwe, input logic [15:0] caddr,
                        input logic [7:0] cwd, input logic eEn, input logic eWe,
                        input logic [15:0] eAddr, input logic [7:0] eWd, input logic eAck,
                        input logic eDv, input logic [7:0] eDd, input logic eStarv,
                        input logic [7:0] eCrd);
    vec_t v;
    v.rst = rst;  v.dreq = dreq; v.daddr = daddr; v.creq = creq; v.cwe = cwe;
    v.caddr = caddr; v.cwd = cwd; v.eEn = eEn; v.eWe = eWe; v.eAddr = eAddr;
    v.eWd = eWd; v.eAck = eAck; v.eDv = eDv; v.eDd = eDd; v.eStarv = eStarv;
    v.eCrd = eCrd;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; disp_ena = 1'b0; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(posedge pixel_clk);
    @(posedge pixel_clk);

    // rst dreq daddr  creq we caddr  wd     en we addr    wd    ack dv dd    stv crd
    addVec(1, 1, 16'h0100, 1, 1, 16'h0123, 8'hA5, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    addVec(1, 1, 16'h0100, 1, 1, 16'h0123, 8'hA5, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    addVec(1, 1, 16'h0100, 1, 1, 16'h0123, 8'hA5, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    addVec(0, 0, 16'h0000, 1, 1, 16'h0123, 8'hA5, 1, 1, 16'h0123, 8'hA5, 0, 0, 8'h00, 0, 8'h00);
    addVec(0, 0, 16'h0000, 1, 1, 16'h0123, 8'hA5, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    addVec(0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    addVec(0, 1, 16'h0100, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0100, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    addVec(0, 1, 16'h0101, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0101, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    addVec(0, 1, 16'h0102, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0102, 8'h00, 0, 1, 8'h40, 0, 8'h00);
    addVec(0, 1, 16'h0103, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0103, 8'h00, 0, 1, 8'h41, 0, 8'h00);
    addVec(0, 1, 16'h0104, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0104, 8'h00, 0, 1, 8'h42, 1, 8'h00);
    addVec(0, 0, 16'h0000, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0010, 8'h00, 0, 1, 8'h43, 1, 8'h00);
    addVec(0, 1, 16'h0105, 0, 0, 16'h0010, 8'h00, 1, 0, 16'h0105, 8'h00, 0, 1, 8'h44, 1, 8'h00);
    addVec(0, 1, 16'h0106, 0, 0, 16'h0010, 8'h00, 1, 0, 16'h0106, 8'h00, 1, 0, 8'h00, 1, 8'h3C);
    addVec(0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 1, 8'h45, 1, 8'h3C);
    addVec(0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 1, 8'h46, 1, 8'h3C);
    addVec(0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1, 8'h3C);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d mem_en", i), 32'(a_mem_en), 32'(vecs[i].eEn));
      checkOutput($sformatf("v%0d mem_we", i), 32'(a_mem_we), 32'(vecs[i].eWe));
      checkOutput($sformatf("v%0d mem_addr", i), 32'(a_mem_addr), 32'(vecs[i].eAddr));
      checkOutput($sformatf("v%0d mem_wdata", i), 32'(a_mem_wdata), 32'(vecs[i].eWd));
      checkOutput($sformatf("v%0d cpu_ack", i), 32'(a_cpu_ack), 32'(vecs[i].eAck));
      checkOutput($sformatf("v%0d disp_rvalid", i), 32'(a_disp_rvalid), 32'(vecs[i].eDv));
      if (vecs[i].eDv) begin
        checkOutput($sformatf("v%0d disp_rdata", i), 32'(a_disp_rdata), 32'(vecs[i].eDd));
      end
      checkOutput($sformatf("v%0d cpu_starved", i), 32'(a_cpu_starved), 32'(vecs[i].eStarv));
      checkOutput($sformatf("v%0d cpu_rdata", i), 32'(a_cpu_rdata), 32'(vecs[i].eCrd));
    end

    // Blanking-only CPU access on dutB: no grant while disp_ena=1.
    driveCycle(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    for (int k = 0; k < 3; k++) begin
      driveCycle(0, 1, 0, 16'h0000, 1, 1, 16'h0200, 8'h77);
      checkOutput($sformatf("blank k%0d b mem_en", k), 32'(b_mem_en), 32'd0);
      checkOutput($sformatf("blank k%0d b cpu_ack", k), 32'(b_cpu_ack), 32'd0);
      if (k == 0) begin
        checkOutput("blank a grants in active video", 32'(a_mem_en), 32'd1);
      end
    end
    driveCycle(0, 0, 0, 16'h0000, 1, 1, 16'h0200, 8'h77);
    checkOutput("blank b mem_en", 32'(b_mem_en), 32'd1);
    checkOutput("blank b mem_we", 32'(b_mem_we), 32'd1);
    checkOutput("blank b mem_addr", 32'(b_mem_addr), 32'h0200);
    checkOutput("blank b mem_wdata", 32'(b_mem_wdata), 32'h77);
    checkOutput("blank b cpu_ack early", 32'(b_cpu_ack), 32'd0);
    driveCycle(0, 0, 0, 16'h0000, 1, 1, 16'h0200, 8'h77);
    checkOutput("blank b cpu_ack", 32'(b_cpu_ack), 32'd1);
    checkOutput("blank b mem_en in WR_ACK", 32'(b_mem_en), 32'd0);
    driveCycle(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    checkOutput("blank b cpu_ack drop", 32'(b_cpu_ack), 32'd0);
    checkOutput("blank b ram write", 32'({b_wseen, b_waddr, b_wdata}), 32'({1'b1, 16'h0200, 8'h77}));

    // Starvation on dutA (limit 4): display busy 10 cycles, CPU waiting.
    driveCycle(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    for (int k = 0; k < 10; k++) begin
      driveCycle(0, 0, 1, 16'h0100 + 16'(k), 1, 0, 16'h0011, 8'h00);
      checkOutput($sformatf("starve k%0d", k), 32'(a_cpu_starved), (k >= 4) ? 32'd1 : 32'd0);
    end
    checkOutput("starve b below limit", 32'(b_cpu_starved), 32'd0);
    driveCycle(0, 0, 0, 16'h0000, 1, 0, 16'h0011, 8'h00);
    checkOutput("starve grant addr", 32'({a_mem_en, a_mem_addr}), 32'({1'b1, 16'h0011}));
    checkOutput("starve after grant", 32'(a_cpu_starved), 32'd1);
    driveCycle(0, 0, 0, 16'h0000, 1, 0, 16'h0011, 8'h00);
    driveCycle(0, 0, 0, 16'h0000, 1, 0, 16'h0011, 8'h00);
    checkOutput("starve ack", 32'(a_cpu_ack), 32'd1);
    checkOutput("starve rdata", 32'(a_cpu_rdata), 32'h51);
    driveCycle(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    checkOutput("starve sticky", 32'(a_cpu_starved), 32'd1);

    // Reset while a display read is in flight drops its data-valid.
    driveCycle(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    driveCycle(0, 0, 1, 16'h0100, 0, 0, 16'h0000, 8'h00);
    checkOutput("drop disp issue", 32'(a_mem_en), 32'd1);
    driveCycle(1, 0, 1, 16'h0101, 0, 0, 16'h0000, 8'h00);
    checkOutput("drop no mem_en in reset", 32'(a_mem_en), 32'd0);
    driveCycle(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    checkOutput("drop disp_rvalid c2", 32'(a_disp_rvalid), 32'd0);
    checkOutput("drop starved cleared", 32'(a_cpu_starved), 32'd0);
    driveCycle(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    checkOutput("drop disp_rvalid c3", 32'(a_disp_rvalid), 32'd0);

    // Reset in RD_WAIT: no ack, FSM back in IDLE, next read served normally.
    driveCycle(0, 0, 0, 16'h0000, 1, 0, 16'h0010, 8'h00);
    checkOutput("rdwait grant", 32'({a_mem_en, a_mem_we, a_mem_addr}), 32'({1'b1, 1'b0, 16'h0010}));
    driveCycle(1, 0, 0, 16'h0000, 1, 0, 16'h0010, 8'h00);
    driveCycle(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    checkOutput("rdwait no ack c2", 32'(a_cpu_ack), 32'd0);
    checkOutput("rdwait rdata cleared", 32'(a_cpu_rdata), 32'd0);
    driveCycle(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    checkOutput("rdwait no ack c3", 32'(a_cpu_ack), 32'd0);
    driveCycle(0, 0, 0, 16'h0000, 1, 0, 16'h0011, 8'h00);
    checkOutput("rdwait regrant", 32'({a_mem_en, a_mem_addr}), 32'({1'b1, 16'h0011}));
    driveCycle(0, 0, 0, 16'h0000, 1, 0, 16'h0011, 8'h00);
    checkOutput("rdwait ack not early", 32'(a_cpu_ack), 32'd0);
    driveCycle(0, 0, 0, 16'h0000, 1, 0, 16'h0011, 8'h00);
    checkOutput("rdwait ack", 32'(a_cpu_ack), 32'd1);
    checkOutput("rdwait rdata", 32'(a_cpu_rdata), 32'h51);
    driveCycle(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00);
    checkOutput("rdwait ack pulse", 32'(a_cpu_ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
